// File: rtl/vx_gpr_pkg.sv
// Shared GPR types: state encoding, {wid, index} register address, register-file depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Build defaults for NUM_THREADS/XLEN/NUM_WARPS are supplied here when not predefined.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

package vx_gpr_pkg;

    localparam int GPR_REGS  = 32;
    localparam int GPR_IDX_W = 5;
    localparam int GPR_WID_W = (`NUM_WARPS > 1) ? $clog2(`NUM_WARPS) : 1;
    localparam int GPR_DEPTH = `NUM_WARPS * GPR_REGS;

    // Register address as stored in the bank: warp id above the 5-bit register index.
    typedef struct packed {
        logic [GPR_WID_W-1:0] wid;
        logic [GPR_IDX_W-1:0] idx;
    } gpr_addr_t;

    // Reader FSM states, kept as plain constants so the encoding is stable across tools.
    typedef logic [2:0] gpr_state_t;
    localparam gpr_state_t ST_IDLE = 3'd0;
    localparam gpr_state_t ST_RD1  = 3'd1;
    localparam gpr_state_t ST_RD2  = 3'd2;
    localparam gpr_state_t ST_RD3  = 3'd3;
    localparam gpr_state_t ST_LAST = 3'd4;
    localparam gpr_state_t ST_RSP  = 3'd5;

    // x0 is hard-wired to zero: reads return zero and writes are dropped.
    function automatic logic is_x0(input gpr_addr_t a);
        return a.idx == '0;
    endfunction

endpackage

// File: rtl/vx_gpr_bank.sv
// Single-read-port register bank, NUM_WARPS*32 entries, per-lane write mask, write-first bypass.
// Latency: read data valid the cycle after the address is presented.
// Backpressure: none; a read and a write are accepted every cycle.
module vx_gpr_bank
    import vx_gpr_pkg::*;
#(
    parameter int NUM_THREADS = `NUM_THREADS,
    parameter int XLEN        = `XLEN,
    parameter int DEPTH       = GPR_DEPTH
) (
    input  logic                               clk,
    input  gpr_addr_t                          rd_addr,
    output logic [NUM_THREADS-1:0][XLEN-1:0]   rd_data,
    input  logic                               wr_en,
    input  gpr_addr_t                          wr_addr,
    input  logic [NUM_THREADS-1:0]             wr_mask,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]   wr_data
);

    logic [NUM_THREADS-1:0][XLEN-1:0] mem [DEPTH];
    logic                             wr_ok;
    logic                             wr_hit;

    assign wr_ok  = wr_en && !is_x0(wr_addr);
    assign wr_hit = wr_ok && (wr_addr == rd_addr);

    // Masked lane write; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_THREADS; l++) begin
            if (wr_ok && wr_mask[l]) begin
                mem[wr_addr][l] <= wr_data[l];
            end
        end
    end

    // Registered read: x0 reads zero, same-address masked lanes see this cycle's write data.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_THREADS; l++) begin
            if (is_x0(rd_addr)) begin
                rd_data[l] <= '0;
            end else if (wr_hit && wr_mask[l]) begin
                rd_data[l] <= wr_data[l];
            end else begin
                rd_data[l] <= mem[rd_addr][l];
            end
        end
    end

endmodule

// File: rtl/vx_gpr_reader.sv
// Reads rs1/rs2/(rs3) of one warp sequentially through a single-port bank; optional rs3 via VX_GPR_RS3_EN.
// Latency: resp_valid 5 cycles after accept (6 when rs3 is read).
// Backpressure: req_ready only when idle; response held stable until resp_ready.
module vx_gpr_reader
    import vx_gpr_pkg::*;
#(
    parameter  int NUM_THREADS = `NUM_THREADS,
    parameter  int XLEN        = `XLEN,
    parameter  int NUM_WARPS   = `NUM_WARPS,
    localparam int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int DATA_W      = NUM_THREADS * XLEN
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WID_W-1:0]       req_wid,
    input  logic [4:0]             req_rs1,
    input  logic [4:0]             req_rs2,
    input  logic [4:0]             req_rs3,
    input  logic                   req_use_rs3,
    input  logic                   wr_en,
    input  logic [WID_W-1:0]       wr_wid,
    input  logic [4:0]             wr_rd,
    input  logic [NUM_THREADS-1:0] wr_tmask,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_W-1:0]      rs1_data,
    output logic [DATA_W-1:0]      rs2_data,
    output logic [DATA_W-1:0]      rs3_data
);

    typedef struct packed {
        logic [WID_W-1:0] wid;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
    } req_t;

    gpr_state_t                       state_q;
    gpr_state_t                       state_d;
    req_t                             req_q;
    logic                             ready_en_q;
    logic                             accept;
    logic [1:0]                       issue_d;
    logic [1:0]                       issued_q;
    logic [4:0]                       rd_idx;
    gpr_addr_t                        rd_addr;
    gpr_addr_t                        wr_addr;
    logic [NUM_THREADS-1:0][XLEN-1:0] bank_rd_dat;
    logic [DATA_W-1:0]                rs1_q;
    logic [DATA_W-1:0]                rs2_q;
    logic                             resp_vld_q;
    logic                             rs3_needed;

    // Ready is held low until the first clock edge after reset release.
    assign req_ready  = ready_en_q && (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = resp_vld_q;
    assign rs1_data   = rs1_q;
    assign rs2_data   = rs2_q;

`ifdef VX_GPR_RS3_EN
    logic [4:0]        rs3_idx_q;
    logic              use_rs3_q;
    logic [DATA_W-1:0] rs3_q;

    assign rs3_needed = use_rs3_q;
    assign rs3_data   = rs3_q;

    // Third-operand request fields and capture; cleared at accept so an rs3-less read returns zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs3_idx_q <= '0;
            use_rs3_q <= 1'b0;
            rs3_q     <= '0;
        end else if (accept) begin
            rs3_idx_q <= req_rs3;
            use_rs3_q <= req_use_rs3;
            rs3_q     <= '0;
        end else if (issued_q == 2'd3) begin
            rs3_q <= bank_rd_dat;
        end
    end
`else
    logic rs3_unused;

    assign rs3_needed = 1'b0;
    assign rs3_data   = '0;
    assign rs3_unused = ^{req_rs3, req_use_rs3};
`endif

    // Next-state: fixed read sequence, third read only when requested.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RD1;
            ST_RD1:  state_d = ST_RD2;
            ST_RD2:  state_d = rs3_needed ? ST_RD3 : ST_LAST;
            ST_RD3:  state_d = ST_LAST;
            ST_LAST: state_d = ST_RSP;
            ST_RSP:  if (resp_vld_q && resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bank read address per state; issue_d tags which operand the bank returns next cycle.
    always_comb begin
        rd_idx  = '0;
        issue_d = 2'd0;
        case (state_q)
            ST_RD1: begin
                rd_idx  = req_q.rs1;
                issue_d = 2'd1;
            end
            ST_RD2: begin
                rd_idx  = req_q.rs2;
                issue_d = 2'd2;
            end
`ifdef VX_GPR_RS3_EN
            ST_RD3: begin
                rd_idx  = rs3_idx_q;
                issue_d = 2'd3;
            end
`endif
            default: begin
                rd_idx  = '0;
                issue_d = 2'd0;
            end
        endcase
        rd_addr.wid = req_q.wid;
        rd_addr.idx = rd_idx;
        wr_addr.wid = wr_wid;
        wr_addr.idx = wr_rd;
    end

    // FSM, latched request and operand capture one cycle after each issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
            req_q      <= '0;
            issued_q   <= 2'd0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            issued_q   <= issue_d;
            if (accept) begin
                req_q.wid <= req_wid;
                req_q.rs1 <= req_rs1;
                req_q.rs2 <= req_rs2;
            end
            if (issued_q == 2'd1) rs1_q <= bank_rd_dat;
            if (issued_q == 2'd2) rs2_q <= bank_rd_dat;
        end
    end

    // resp_valid rises from a flop one cycle into RSP and drops on the handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_vld_q <= 1'b0;
        end else if (resp_vld_q && resp_ready) begin
            resp_vld_q <= 1'b0;
        end else if (state_q == ST_RSP) begin
            resp_vld_q <= 1'b1;
        end
    end

    vx_gpr_bank #(
        .NUM_THREADS (NUM_THREADS),
        .XLEN        (XLEN),
        .DEPTH       (NUM_WARPS * GPR_REGS)
    ) u_bank (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_data (bank_rd_dat),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_mask (wr_tmask),
        .wr_data (wr_data)
    );

endmodule

// File: tb/tb_vx_gpr_reader.sv
// Bench for vx_gpr_reader: directed cases plus randomized requests against a register-file model.
// Latency: expected 5 cycles after accept, 6 when rs3 is read in an rs3-enabled build.
// Backpressure: resp_ready withheld for random spans; response must stay stable meanwhile.
module tb_vx_gpr_reader;

    localparam int NT = 4;
    localparam int XL = 32;
    localparam int NW = 4;
    localparam int WW = 2;
    localparam int DW = NT * XL;
`ifdef VX_GPR_RS3_EN
    localparam bit RS3_ON = 1'b1;
`else
    localparam bit RS3_ON = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [WW-1:0] req_wid;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [4:0]    req_rs3;
    logic          req_use_rs3;
    logic          wr_en;
    logic [WW-1:0] wr_wid;
    logic [4:0]    wr_rd;
    logic [NT-1:0] wr_tmask;
    logic [DW-1:0] wr_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [DW-1:0] rs3_data;

    int checks = 0;
    int errors = 0;

    // Reference register file: one DW-wide word per {warp, index}.
    logic [DW-1:0] ref_mem [NW*32];

    vx_gpr_reader #(
        .NUM_THREADS (NT),
        .XLEN        (XL),
        .NUM_WARPS   (NW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wid     (req_wid),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rs3     (req_rs3),
        .req_use_rs3 (req_use_rs3),
        .wr_en       (wr_en),
        .wr_wid      (wr_wid),
        .wr_rd       (wr_rd),
        .wr_tmask    (wr_tmask),
        .wr_data     (wr_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs3_data    (rs3_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ref_read(input int wid, input int idx);
        if (idx == 0) return '0;
        return ref_mem[wid*32 + idx];
    endfunction

    function automatic logic [DW-1:0] rand_dat();
        logic [DW-1:0] d;
        for (int l = 0; l < NT; l++) d[l*XL +: XL] = $urandom;
        return d;
    endfunction

    function automatic logic [DW-1:0] splat(input logic [XL-1:0] v);
        logic [DW-1:0] d;
        for (int l = 0; l < NT; l++) d[l*XL +: XL] = v;
        return d;
    endfunction

    // Drive one write for the current cycle and apply it to the model (x0 writes are dropped).
    task automatic drive_write(input int wid, input int idx, input logic [NT-1:0] mask, input logic [DW-1:0] data);
        wr_en    = 1'b1;
        wr_wid   = WW'(wid);
        wr_rd    = 5'(idx);
        wr_tmask = mask;
        wr_data  = data;
        if (idx != 0) begin
            for (int l = 0; l < NT; l++) begin
                if (mask[l]) ref_mem[wid*32 + idx][l*XL +: XL] = data[l*XL +: XL];
            end
        end
    endtask

    task automatic idle_write(input int wid, input int idx, input logic [NT-1:0] mask, input logic [DW-1:0] data);
        drive_write(wid, idx, mask, data);
        tick();
        wr_en = 1'b0;
    endtask

    // One read transaction. An operand read in cycle N+k sees every write made in cycles up to and
    // including N+k (k=1 rs1, k=2 rs2, k=3 rs3). inj_k>0 injects a write in cycle N+inj_k.
    task automatic do_req(input string tag, input int wid, input int r1, input int r2, input int r3,
                          input bit use3, input int hold, input int inj_k, input int inj_wid,
                          input int inj_rd, input logic [NT-1:0] inj_mask, input logic [DW-1:0] inj_dat);
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic [DW-1:0] e3;
        bit            seen;
        int            lat;
        int            exp_lat;
        bit            rd3;
        rd3     = RS3_ON && use3;
        exp_lat = rd3 ? 6 : 5;
        e1 = '0;
        e2 = '0;
        e3 = '0;
        chk({tag, "_ready_before"}, DW'(req_ready), DW'(1));
        req_valid   = 1'b1;
        req_wid     = WW'(wid);
        req_rs1     = 5'(r1);
        req_rs2     = 5'(r2);
        req_rs3     = 5'(r3);
        req_use_rs3 = use3;
        resp_ready  = (hold == 0);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            tick();
            req_valid   = 1'b0;
            req_wid     = WW'($urandom_range(NW-1));
            req_rs1     = 5'($urandom_range(31));
            req_rs2     = 5'($urandom_range(31));
            req_rs3     = 5'($urandom_range(31));
            req_use_rs3 = 1'($urandom_range(1));
            wr_en       = 1'b0;
            if (k == inj_k) drive_write(inj_wid, inj_rd, inj_mask, inj_dat);
            if (k == 1) e1 = ref_read(wid, r1);
            if (k == 2) e2 = ref_read(wid, r2);
            if (k == 3 && rd3) e3 = ref_read(wid, r3);
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        wr_en = 1'b0;
        chk({tag, "_latency"}, DW'(lat), DW'(exp_lat));
        if (!seen) return;
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) resp_ready = 1'b1;
            chk({tag, "_valid"}, DW'(resp_valid), DW'(1));
            chk({tag, "_rs1"}, rs1_data, e1);
            chk({tag, "_rs2"}, rs2_data, e2);
            chk({tag, "_rs3"}, rs3_data, e3);
            tick();
        end
        resp_ready = 1'b0;
        chk({tag, "_valid_after"}, DW'(resp_valid), DW'(0));
        chk({tag, "_ready_after"}, DW'(req_ready), DW'(1));
    endtask

    initial begin
        bit seen_rsp;
        int wid;
        int r1;
        int r2;
        int r3;
        int irs;

        reset_n     = 1'b1;
        req_valid   = 1'b0;
        req_wid     = '0;
        req_rs1     = '0;
        req_rs2     = '0;
        req_rs3     = '0;
        req_use_rs3 = 1'b0;
        wr_en       = 1'b0;
        wr_wid      = '0;
        wr_rd       = '0;
        wr_tmask    = '0;
        wr_data     = '0;
        resp_ready  = 1'b0;
        #1 reset_n = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_req_ready", DW'(req_ready), DW'(0));
        chk("rst_resp_valid", DW'(resp_valid), DW'(0));
        chk("rst_rs1", rs1_data, '0);
        chk("rst_rs2", rs2_data, '0);
        chk("rst_rs3", rs3_data, '0);
        reset_n = 1'b1;
        tick();
        chk("rel_req_ready", DW'(req_ready), DW'(1));

        // Fill every entry so all reads have defined contents.
        for (int a = 0; a < NW*32; a++) begin
            drive_write(a / 32, a % 32, '1, rand_dat());
            tick();
        end
        wr_en = 1'b0;

        // Basic two-operand read.
        idle_write(0, 5, '1, splat(32'h11111111));
        idle_write(0, 6, '1, splat(32'h22222222));
        idle_write(0, 7, '1, splat(32'h33333333));
        do_req("basic", 0, 5, 6, 7, 1'b0, 0, 0, 0, 0, '0, '0);

        // Third operand with four cycles of backpressure.
        do_req("rs3_bp", 0, 5, 6, 7, 1'b1, 4, 0, 0, 0, '0, '0);

        // x0 always reads zero even after a write to it.
        idle_write(0, 0, '1, '1);
        do_req("x0", 0, 0, 5, 0, 1'b1, 1, 0, 0, 0, '0, '0);

        // Write to the rs1 address in the rs1 issue cycle, lanes 0 and 2 only.
        idle_write(1, 9, '1, splat(32'hA0A0A0A0));
        do_req("bypass", 1, 9, 0, 0, 1'b0, 0, 1, 1, 9, 4'b0101, splat(32'h5C5C5C5C));

        // Reset asserted while the reader is in RD2.
        req_valid   = 1'b1;
        req_wid     = '0;
        req_rs1     = 5'd5;
        req_rs2     = 5'd6;
        req_use_rs3 = 1'b0;
        resp_ready  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_resp_valid", DW'(resp_valid), DW'(0));
        chk("midrst_req_ready", DW'(req_ready), DW'(0));
        chk("midrst_rs1", rs1_data, '0);
        tick();
        tick();
        reset_n  = 1'b1;
        seen_rsp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (resp_valid !== 1'b0) seen_rsp = 1'b1;
        end
        chk("midrst_no_resp", DW'(seen_rsp), DW'(0));
        chk("midrst_ready", DW'(req_ready), DW'(1));
        resp_ready = 1'b0;
        do_req("after_rst", 0, 5, 6, 7, 1'b0, 0, 0, 0, 0, '0, '0);

        // Same index in the first and last warp holds different values.
        idle_write(0, 3, '1, splat(32'hCAFE0000));
        idle_write(NW-1, 3, '1, splat(32'hBEEF0003));
        do_req("warp_lo", 0, 3, 3, 3, 1'b1, 0, 0, 0, 0, '0, '0);
        do_req("warp_hi", NW-1, 3, 3, 3, 1'b1, 0, 0, 0, 0, '0, '0);

        // Randomized requests with idle writes, in-flight writes and backpressure.
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(1) == 1) begin
                idle_write($urandom_range(NW-1), $urandom_range(31), 4'($urandom_range(15)), rand_dat());
            end
            wid = $urandom_range(NW-1);
            r1  = ($urandom_range(4) == 0) ? 0 : $urandom_range(31);
            r2  = ($urandom_range(4) == 0) ? 0 : $urandom_range(31);
            r3  = ($urandom_range(4) == 0) ? 0 : $urandom_range(31);
            case ($urandom_range(3))
                0:       irs = r1;
                1:       irs = r2;
                2:       irs = r3;
                default: irs = $urandom_range(31);
            endcase
            do_req("rand", wid, r1, r2, r3, 1'($urandom_range(1)), $urandom_range(3),
                   $urandom_range(3), ($urandom_range(1) == 1) ? wid : $urandom_range(NW-1),
                   irs, 4'($urandom_range(15)), rand_dat());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_gpr_reader.md
VX_GPR_READER -- requirements
Module: VX_gpr_reader

Interface
REQ-001 SHALL have parameter NUM_THREADS, default `NUM_THREADS, lanes per warp.
REQ-002 SHALL have parameter XLEN, default `XLEN, register width in bits.
REQ-003 SHALL have parameter NUM_WARPS, default `NUM_WARPS, warps sharing the file; 32 registers per warp.
REQ-004 SHALL use one clock and an asynchronous active-low reset; ports: clk  in  1  clock; reset_n  in  1  async active-low reset.
REQ-005 SHALL have req_valid  in  1  read request valid; req_ready  out  1  reader idle.
REQ-006 SHALL have req_wid  in  log2(NUM_WARPS)  warp id; req_rs1/req_rs2/req_rs3  in  5 each  source indices; req_use_rs3  in  1  rs3 needed.
REQ-007 SHALL have wr_en  in  1  writeback; wr_wid  in  log2(NUM_WARPS); wr_rd  in  5; wr_tmask  in  NUM_THREADS  lane mask; wr_data  in  NUM_THREADS*XLEN.
REQ-008 SHALL have resp_valid  out  1; resp_ready  in  1; rs1_data/rs2_data/rs3_data  out  NUM_THREADS*XLEN each  GPR response master side.

Function
REQ-009 SHALL accept a request on the cycle req_valid && req_ready; req_ready SHALL be 1 only in IDLE.
REQ-010 SHALL sequence states IDLE -> RD1 -> RD2 -> RD3 (only if req_use_rs3) -> LAST -> RSP -> IDLE.
REQ-011 SHALL issue rs1, rs2, rs3 addresses in RD1, RD2, RD3 respectively to a single-read-port synchronous RAM (1-cycle read latency) and capture each result one cycle after issue.
REQ-012 SHALL assert resp_valid in cycle N+5 (use_rs3=0) or N+6 (use_rs3=1) after accept cycle N.
REQ-013 SHALL hold resp_valid and all rs*_data stable in RSP until resp_ready; RSP->IDLE on resp_valid && resp_ready.
REQ-014 SHALL drive rs3_data to zero when req_use_rs3=0.
REQ-015 SHALL return all-zero data for any source index 0, regardless of RAM contents.
REQ-016 SHALL write wr_data lanes selected by wr_tmask into entry {wr_wid, wr_rd} every cycle wr_en=1, independent of FSM state; writes to index 0 ignored.
REQ-017 SHALL forward write data (per masked lane, write-first) when a read address equals the same-cycle write address.
REQ-018 SHALL latch request fields at accept; later changes on req_* SHALL not affect the in-flight read.

Reset
REQ-019 SHALL, while reset_n=0, force state IDLE, resp_valid=0, rs*_data=0, req_ready=0; req_ready=1 from first clock after deassertion.
REQ-020 SHALL abandon any in-flight request on reset assertion mid-sequence; no response produced for it.
REQ-021 SHALL not reset RAM contents.

Configuration
REQ-022 SHALL honour macro VX_GPR_RS3_EN: defined -> RD3 state, rs3 read and rs3_data as specified; undefined -> RD3 omitted, req_use_rs3 ignored, rs3_data tied zero, latency always N+5.

Structure
REQ-023 SHALL place state enum, GPR address typedef ({wid, index}) and RAM depth localparam (NUM_WARPS*32) in shared package VX_gpr_pkg.
REQ-024 SHALL instantiate one sub-module VX_gpr_bank: sync-read RAM with per-lane write mask and write-first bypass.

Verification
REQ-025 SHALL test basic read: write w0 x5=0x11..., x6=0x22...; request rs1=5,rs2=6,use_rs3=0 at N -> resp_valid at N+5, rs1=0x11.., rs2=0x22.., rs3=0.
REQ-026 SHALL test rs3 and backpressure: use_rs3=1, rs3=7 holding 0x33..; resp_ready low 4 cycles -> resp_valid at N+6, data stable until handshake.
REQ-027 SHALL test x0: write x0=0xFFFF...; read rs1=0 -> rs1_data=0.
REQ-028 SHALL test bypass: wr_en to w1 x9 with tmask=0b0101 in the rs1-issue cycle -> lanes 0,2 new value, lanes 1,3 old value.
REQ-029 SHALL test reset mid-read: reset_n low in RD2 -> resp_valid stays 0, req_ready=1 after release, next request answered correctly.
REQ-030 SHALL test warp isolation: same index x3 written differently in w0 and w(NUM_WARPS-1) -> each read returns its own warp's value.
